core_dbg_regs: RTL
==================

Name: core_dbg_regs

Overview:
- Core-side responder for the Core Debug Interface register map. Offsets: 0 DBGSC, 1 DRUNCTRL, 2-5 ITR0-ITR3, 6 DTR_HI, 7 DTR_LO.
- Accepts single-outstanding register accesses from the external debug transport and drives halt, resume and step requests into the pipeline.
- Sequences ITR0-ITR3 into the pipeline instruction-injection port and holds the 64-bit DTR shared between host and core.

Parameters:
- DBG_ADDR_WIDTH, 4, register offset width (DbgIfaceReg encoding)
- DBG_DATA_WIDTH, 32, host access data width
- INSN_WIDTH, 32, injected instruction width
- REG_WIDTH, 64, DTR width (core register width)

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  host access request valid
- req_ready  out  1  block can accept a request
- req_write  in  1  1=write, 0=read
- req_addr  in  4  register offset
- req_wdata  in  32  write data
- rsp_valid  out  1  response valid
- rsp_ready  in  1  host accepts response
- rsp_rdata  out  32  read data (0 for writes)
- rsp_err  out  1  access or execution error
- dbg_en  out  1  debug enabled (DBGSC bit 0)
- halt_req  out  1  halt request level
- resume_req  out  1  one-cycle resume pulse
- step_req  out  1  one-cycle single-step pulse
- core_halted  in  1  pipeline is halted
- itr_valid  out  1  injected instruction valid
- itr_ready  in  1  pipeline accepts injected instruction
- itr_insn  out  32  injected instruction
- itr_done  in  1  injected instruction retired
- itr_exc  in  1  injected instruction faulted (qualified by itr_done)
- dtr_core_we  in  1  core writes DTR
- dtr_core_wdata  in  64  core DTR write data
- dtr_rdata  out  64  current DTR value to core

Behaviour:
- Reset values: every output 0; ITR0-3 = 0; DTR = 0; FSM in IDLE.
- Reset mid-operation aborts everything immediately, including any ITR sequence or pending response.
- FSM states: IDLE, RESP, ITR_ISSUE, ITR_WAIT.
- req_ready = 1 only in IDLE. A request is accepted when req_valid && req_ready.
- Latency: rsp_valid rises the cycle after acceptance, except ITR3 writes that start execution.
- RESP holds rsp_valid, rsp_rdata and rsp_err stable until rsp_ready, then returns to IDLE. Back-to-back requests therefore take at least 2 cycles each.
- Offsets 8-15: response with rsp_err = 1, no side effects.
- Reads of offsets 0-5 (write-only): rsp_rdata = 0, rsp_err = 1.
- DBGSC write: dbg_en <= wdata[0].
- DRUNCTRL write: bit0 sets halt_req; bit1 resume; bit2 step. Bit0 wins over bits 1-2 in the same write.
  - halt_req stays high until core_halted is sampled 1, then clears.
  - resume_req and step_req pulse for 1 cycle, only if dbg_en && core_halted; otherwise rsp_err = 1 and no pulse.
  - Bits 1 and 2 set together: step wins.
- ITR0-ITR2 write: store wdata, rsp_err = 0.
- ITR3 write: store wdata.
  - If !dbg_en || !core_halted: immediate response with rsp_err = 1, no execution.
  - Otherwise load the 2-bit index with the lowest n in 0..2 whose ITRn is nonzero, else 3, and go to ITR_ISSUE. A zero ITR0-ITR2 slot is skipped; ITR3 always issues.
- ITR_ISSUE: itr_valid = 1, itr_insn = ITR[index]. On itr_ready go to ITR_WAIT with itr_valid = 0.
- ITR_WAIT, on itr_done:
  - itr_exc = 1: abort the remaining slots and go to RESP with rsp_err = 1.
  - index == 3: go to RESP with rsp_err = 0.
  - Otherwise advance to the next nonzero slot, or to 3, and return to ITR_ISSUE.
  - itr_done in the same cycle as the itr_ready handshake is ignored.
- DTR writes:
  - Host DTR_HI write updates bits [63:32]; DTR_LO write updates bits [31:0].
  - dtr_core_we writes all 64 bits.
  - Same-cycle conflict: core write wins; the host write is dropped but still responds rsp_err = 0.
- DTR reads: DTR_HI returns [63:32], DTR_LO returns [31:0], sampled at acceptance.
- dtr_rdata reflects the register combinationally from the flop output.

Test Plan:
- Reset, then read DTR_LO -> rsp_rdata = 0x0, rsp_err = 0; read ITR0 -> rsp_err = 1; read offset 9 -> rsp_err = 1.
- Write DBGSC = 0x1; DRUNCTRL = 0x1; core_halted rises 3 cycles later -> halt_req high exactly until the cycle after core_halted is sampled, dbg_en = 1.
- Halted: write ITR0 = 0x00100093, ITR1 = 0, ITR2 = 0x00200113, ITR3 = 0x00000013 -> itr_insn sequence 0x00100093, 0x00200113, 0x00000013; single response rsp_err = 0 after the third itr_done; req_ready low throughout.
- Same sequence with itr_exc = 1 on the first itr_done -> no further itr_valid, rsp_err = 1.
- Core not halted, write ITR3 -> immediate rsp_err = 1, itr_valid never asserts.
- Host writes DTR_HI = 0xDEADBEEF in the same cycle as dtr_core_we with 0x1122334455667788 -> read DTR_HI returns 0x11223344; rsp_ready held low for 5 cycles -> response stable throughout.

Source files
------------

// File: rtl/core_dbg_regs.sv
// Core-side responder for the debug register map.
// Host side: one outstanding access at a time. A request transfers when
// req_valid && req_ready; the response transfers when rsp_valid && rsp_ready,
// and rsp_rdata/rsp_err stay stable while rsp_valid waits for rsp_ready.
// Core side: drives halt/resume/step, injects ITR0-ITR3 through a
// valid/ready port (itr_valid held until itr_ready), waits for itr_done per
// slot, and holds the 64-bit DTR shared between host and core.
module core_dbg_regs #(
    parameter int DBG_ADDR_WIDTH = 4,
    parameter int DBG_DATA_WIDTH = 32,
    parameter int INSN_WIDTH     = 32,
    parameter int REG_WIDTH      = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [DBG_ADDR_WIDTH-1:0] req_addr,
    input  logic [DBG_DATA_WIDTH-1:0] req_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DBG_DATA_WIDTH-1:0] rsp_rdata,
    output logic                      rsp_err,
    output logic                      dbg_en,
    output logic                      halt_req,
    output logic                      resume_req,
    output logic                      step_req,
    input  logic                      core_halted,
    output logic                      itr_valid,
    input  logic                      itr_ready,
    output logic [INSN_WIDTH-1:0]     itr_insn,
    input  logic                      itr_done,
    input  logic                      itr_exc,
    input  logic                      dtr_core_we,
    input  logic [REG_WIDTH-1:0]      dtr_core_wdata,
    output logic [REG_WIDTH-1:0]      dtr_rdata
);

    localparam int HALF = REG_WIDTH / 2;

    localparam logic [DBG_ADDR_WIDTH-1:0] A_DBGSC    = DBG_ADDR_WIDTH'(0);
    localparam logic [DBG_ADDR_WIDTH-1:0] A_DRUNCTRL = DBG_ADDR_WIDTH'(1);
    localparam logic [DBG_ADDR_WIDTH-1:0] A_ITR0     = DBG_ADDR_WIDTH'(2);
    localparam logic [DBG_ADDR_WIDTH-1:0] A_ITR1     = DBG_ADDR_WIDTH'(3);
    localparam logic [DBG_ADDR_WIDTH-1:0] A_ITR2     = DBG_ADDR_WIDTH'(4);
    localparam logic [DBG_ADDR_WIDTH-1:0] A_ITR3     = DBG_ADDR_WIDTH'(5);
    localparam logic [DBG_ADDR_WIDTH-1:0] A_DTR_HI   = DBG_ADDR_WIDTH'(6);
    localparam logic [DBG_ADDR_WIDTH-1:0] A_DTR_LO   = DBG_ADDR_WIDTH'(7);

    typedef enum logic [1:0] {IDLE, RESP, ITR_ISSUE, ITR_WAIT} state_t;

    state_t                    state, state_nxt;
    logic [1:0]                idx_q, idx_nxt;
    logic [1:0]                first_slot, next_slot;
    logic [INSN_WIDTH-1:0]     itr_q [4];
    logic [REG_WIDTH-1:0]      dtr_q;
    logic                      accept;
    logic                      in_range;
    logic                      run_ok;
    logic                      load_rsp;
    logic [DBG_DATA_WIDTH-1:0] rdata_nxt;
    logic                      err_nxt;

    assign accept    = req_valid && req_ready;
    assign in_range  = (req_addr <= A_DTR_LO);
    assign run_ok    = dbg_en && core_halted;
    assign rsp_valid = (state == RESP);
    assign itr_valid = (state == ITR_ISSUE);
    assign itr_insn  = (state == ITR_ISSUE) ? itr_q[idx_q] : '0;
    assign dtr_rdata = dtr_q;

    // Slot search: lowest nonzero ITR0-ITR2 overall, and the next one after idx_q; ITR3 is the fallback.
    always_comb begin
        first_slot = 2'd3;
        next_slot  = 2'd3;
        for (int n = 2; n >= 0; n--) begin
            if (itr_q[n] != '0) begin
                first_slot = 2'(n);
                if (n > int'(idx_q)) begin
                    next_slot = 2'(n);
                end
            end
        end
    end

    // FSM state register plus the registered response and ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx_q     <= 2'd0;
            req_ready <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx_q     <= idx_nxt;
            req_ready <= (state_nxt == IDLE);
            if (load_rsp) begin
                rsp_rdata <= rdata_nxt;
                rsp_err   <= err_nxt;
            end
        end
    end

    // FSM next state and response contents.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx_q;
        load_rsp  = 1'b0;
        rdata_nxt = '0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    load_rsp  = 1'b1;
                    state_nxt = RESP;
                    if (!in_range) begin
                        err_nxt = 1'b1;
                    end else if (!req_write) begin
                        if (req_addr == A_DTR_HI) begin
                            rdata_nxt = dtr_q[REG_WIDTH-1:HALF];
                        end else if (req_addr == A_DTR_LO) begin
                            rdata_nxt = dtr_q[HALF-1:0];
                        end else begin
                            err_nxt = 1'b1;
                        end
                    end else if (req_addr == A_DRUNCTRL) begin
                        // Resume/step without a halted, enabled core is an error; halt always wins.
                        if (!req_wdata[0] && (req_wdata[1] || req_wdata[2]) && !run_ok) begin
                            err_nxt = 1'b1;
                        end
                    end else if (req_addr == A_ITR3) begin
                        if (!run_ok) begin
                            err_nxt = 1'b1;
                        end else begin
                            state_nxt = ITR_ISSUE;
                            idx_nxt   = first_slot;
                        end
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            ITR_ISSUE: begin
                if (itr_ready) begin
                    state_nxt = ITR_WAIT;
                end
            end
            ITR_WAIT: begin
                if (itr_done) begin
                    if (itr_exc) begin
                        load_rsp  = 1'b1;
                        err_nxt   = 1'b1;
                        state_nxt = RESP;
                    end else if (idx_q == 2'd3) begin
                        load_rsp  = 1'b1;
                        state_nxt = RESP;
                    end else begin
                        idx_nxt   = next_slot;
                        state_nxt = ITR_ISSUE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Register side effects of host writes, run-control requests and core DTR writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_en     <= 1'b0;
            halt_req   <= 1'b0;
            resume_req <= 1'b0;
            step_req   <= 1'b0;
            dtr_q      <= '0;
            for (int n = 0; n < 4; n++) begin
                itr_q[n] <= '0;
            end
        end else begin
            resume_req <= 1'b0;
            step_req   <= 1'b0;
            if (halt_req && core_halted) begin
                halt_req <= 1'b0;
            end
            if (dtr_core_we) begin
                dtr_q <= dtr_core_wdata;
            end
            if (accept && req_write) begin
                case (req_addr)
                    A_DBGSC:    dbg_en <= req_wdata[0];
                    A_DRUNCTRL: begin
                        if (req_wdata[0]) begin
                            halt_req <= 1'b1;
                        end else if (run_ok) begin
                            if (req_wdata[2]) begin
                                step_req <= 1'b1;
                            end else if (req_wdata[1]) begin
                                resume_req <= 1'b1;
                            end
                        end
                    end
                    A_ITR0:     itr_q[0] <= req_wdata;
                    A_ITR1:     itr_q[1] <= req_wdata;
                    A_ITR2:     itr_q[2] <= req_wdata;
                    A_ITR3:     itr_q[3] <= req_wdata;
                    // Core write on the same edge takes the whole register; host half is dropped.
                    A_DTR_HI: begin
                        if (!dtr_core_we) begin
                            dtr_q[REG_WIDTH-1:HALF] <= req_wdata;
                        end
                    end
                    A_DTR_LO: begin
                        if (!dtr_core_we) begin
                            dtr_q[HALF-1:0] <= req_wdata;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
